// File: rtl/nvdla_tieoff_pkg.sv
// nvdla_tieoff_pkg: FSM states and AXI response codes shared by the null AXI responder.
package nvdla_tieoff_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/null_axi_rd_engine.sv
// null_axi_rd_engine: read-side FSM returning arlen+1 zero-data beats per accepted AR.
module null_axi_rd_engine import nvdla_tieoff_pkg::*; #(
  parameter int ID_W = 8,
  parameter int DATA_W = 64,
  parameter logic [1:0] RESP_CODE = RESP_OKAY
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [7:0]        arlen_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [ID_W-1:0]   rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              done_o
);
  r_state_e state_q;
  logic [ID_W-1:0] id_q;
  logic [7:0] beats_q;
  // arready is held low while reset is asserted, even though the state already reads idle
  assign arready_o = rstn_i && state_q == R_IDLE;
  assign rvalid_o = state_q == R_DATA;
  assign rid_o = id_q;
  assign rdata_o = '0;
  assign rresp_o = RESP_CODE;
  assign rlast_o = rvalid_o && beats_q == 8'd0;
  assign done_o = rvalid_o && rready_i && rlast_o;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= R_IDLE;
      id_q <= '0;
      beats_q <= '0;
    end else if (arvalid_i && arready_o) begin
      state_q <= R_DATA;
      id_q <= arid_i;
      beats_q <= arlen_i;
    end else if (rvalid_o && rready_i) begin
      state_q <= rlast_o ? R_IDLE : R_DATA;
      beats_q <= beats_q - {7'd0, !rlast_o};
    end
  end
endmodule

// File: rtl/null_axi_responder.sv
// null_axi_responder: terminates an unused AXI master port, completing every
// write and read with RESP_CODE so stray traffic never hangs.
module null_axi_responder import nvdla_tieoff_pkg::*; #(
  parameter int ID_W = 8,
  parameter int DATA_W = 64,
  parameter logic [1:0] RESP_CODE = RESP_OKAY,
  parameter int CNT_W = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [7:0]        awlen,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [7:0]        arlen,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              hit
);
  w_state_e w_state_q;
  logic [ID_W-1:0] bid_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic hit_q, rd_done, aw_hs, ar_hs, unused;
  null_axi_rd_engine #(.ID_W(ID_W), .DATA_W(DATA_W), .RESP_CODE(RESP_CODE)) u_rd (
    .clk_i(nvdla_core_clk), .rstn_i(nvdla_core_rstn),
    .arvalid_i(arvalid), .arready_o(arready), .arid_i(arid), .arlen_i(arlen),
    .rvalid_o(rvalid), .rready_i(rready), .rid_o(rid), .rdata_o(rdata),
    .rresp_o(rresp), .rlast_o(rlast), .done_o(rd_done)
  );
  // burst end comes from wlast, so awlen and the data itself are dropped
  assign unused = ^{awlen, wdata};
  assign awready = nvdla_core_rstn && w_state_q == W_IDLE;
  assign wready = w_state_q == W_DATA;
  assign bvalid = w_state_q == W_RESP;
  assign bid = bid_q;
  assign bresp = RESP_CODE;
  assign aw_hs = awvalid && awready;
  assign ar_hs = arvalid && arready;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
  assign hit = hit_q;
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      w_state_q <= W_IDLE;
      bid_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_q || aw_hs || ar_hs;
      if (bvalid && bready) wr_cnt_q <= wr_cnt_q + {{(CNT_W-1){1'b0}}, ~&wr_cnt_q};
      if (rd_done) rd_cnt_q <= rd_cnt_q + {{(CNT_W-1){1'b0}}, ~&rd_cnt_q};
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          bid_q <= awid;
          w_state_q <= W_DATA;
        end
        W_DATA: if (wvalid && wlast) w_state_q <= W_RESP;
        W_RESP: if (bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_null_axi_responder.sv
// tb_null_axi_responder: random AXI traffic with a queue scoreboard checked by a negedge monitor.
module tb_null_axi_responder;
  localparam int ID_W = 8;
  localparam int DATA_W = 64;
  localparam logic [1:0] RC = 2'b10;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [ID_W-1:0] awid = 0, arid = 0;
  logic [7:0] awlen = 0, arlen = 0;
  logic [DATA_W-1:0] wdata = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast, hit;
  logic [ID_W-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DATA_W-1:0] rdata;
  logic [15:0] wr_cnt, rd_cnt;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast, s_hit;
  logic [ID_W-1:0] s_bid, s_rid;
  logic [1:0] s_bresp, s_rresp, s_wr_cnt, s_rd_cnt;
  logic [DATA_W-1:0] s_rdata;

  null_axi_responder #(.ID_W(ID_W), .DATA_W(DATA_W), .RESP_CODE(RC), .CNT_W(16)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .hit(hit)
  );
  null_axi_responder #(.ID_W(ID_W), .DATA_W(DATA_W), .CNT_W(2)) dut_s (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .awvalid(awvalid), .awready(s_awready), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(s_wready), .wdata(wdata), .wlast(wlast),
    .bvalid(s_bvalid), .bready(bready), .bid(s_bid), .bresp(s_bresp),
    .arvalid(arvalid), .arready(s_arready), .arid(arid), .arlen(arlen),
    .rvalid(s_rvalid), .rready(rready), .rid(s_rid), .rdata(s_rdata), .rresp(s_rresp), .rlast(s_rlast),
    .wr_cnt(s_wr_cnt), .rd_cnt(s_rd_cnt), .hit(s_hit)
  );

  int checks = 0, errors = 0, nw = 0, nr = 0;
  typedef struct packed {logic [ID_W-1:0] id; logic last;} rbeat_t;
  logic [ID_W-1:0] exp_b[$];
  rbeat_t exp_r[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic b_stall = 0, r_stall = 0, r_last_p;
  logic [ID_W-1:0] b_id_p, r_id_p, eb;
  rbeat_t er;
  always @(negedge clk) begin
    if (!rstn) begin
      b_stall = 0;
      r_stall = 0;
    end else begin
      if (b_stall) begin
        chk("b_hold_valid", bvalid, 1);
        chk("b_hold_id", bid, b_id_p);
      end
      if (r_stall) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_id", rid, r_id_p);
        chk("r_hold_last", rlast, r_last_p);
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("bid", bid, eb);
          chk("bresp", bresp, RC);
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          er = exp_r.pop_front();
          chk("rid", rid, er.id);
          chk("rlast", rlast, er.last);
          chk("rdata", rdata, 0);
          chk("rresp", rresp, RC);
        end
      end
      b_stall = bvalid && !bready;
      b_id_p = bid;
      r_stall = rvalid && !rready;
      r_id_p = rid;
      r_last_p = rlast;
    end
  end

  // sel: 0 aw, 1 w, 2 b, 3 ar, 4 r; mode drives ready: 0 random, 1 toggle, 2 held high
  task automatic step_until(input int sel, input int mode, input string name);
    bit h;
    int t;
    h = 0;
    t = 0;
    while (!h && t < 400) begin
      if (sel == 2) bready = mode == 0 ? 1'($urandom % 2) : mode == 1 ? !bready : 1'b1;
      if (sel == 4) rready = mode == 0 ? 1'($urandom % 2) : mode == 1 ? !rready : 1'b1;
      @(negedge clk);
      h = sel == 0 ? awready : sel == 1 ? wready : sel == 2 ? (bvalid && bready) :
          sel == 3 ? arready : (rvalid && rready);
      @(posedge clk);
      #1;
      t++;
    end
    if (!h) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input int beats, input int mode, input bit early);
    if (early) begin
      wvalid = 1;
      repeat (2) begin
        @(negedge clk);
        chk("wready_before_aw", wready, 0);
        @(posedge clk);
        #1;
      end
      wvalid = 0;
    end
    exp_b.push_back(id);
    awvalid = 1;
    awid = id;
    awlen = 8'($urandom);
    step_until(0, 0, "aw");
    awvalid = 0;
    awid = '0;
    chk("wready_latency", wready, 1);
    for (int i = 0; i < beats; i++) begin
      if (mode == 0 && $urandom % 3 == 0) begin
        @(posedge clk);
        #1;
      end
      wvalid = 1;
      wdata = {$urandom, $urandom};
      wlast = i == beats - 1;
      step_until(1, 0, "w");
      wvalid = 0;
      wlast = 0;
    end
    chk("bvalid_latency", bvalid, 1);
    step_until(2, mode, "b");
    bready = 0;
    nw++;
    chk("wr_cnt", wr_cnt, nw);
    chk("wr_cnt_sat", s_wr_cnt, nw > 3 ? 3 : nw);
    chk("bvalid_clear", bvalid, 0);
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [7:0] len, input int mode);
    for (int i = 0; i <= int'(len); i++) exp_r.push_back(rbeat_t'{id: id, last: (i == int'(len))});
    arvalid = 1;
    arid = id;
    arlen = len;
    step_until(3, 0, "ar");
    arvalid = 0;
    chk("rvalid_latency", rvalid, 1);
    for (int i = 0; i <= int'(len); i++) step_until(4, mode, "r");
    rready = 0;
    nr++;
    chk("rd_cnt", rd_cnt, nr);
    chk("rd_cnt_sat", s_rd_cnt, nr > 3 ? 3 : nr);
    chk("rvalid_clear", rvalid, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_hit", hit, 0);
    rstn = 1;
    #1;
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);
    @(posedge clk);
    #1;
    do_write(8'h3C, 4, 2, 1);
    chk("hit_after_write", hit, 1);
    do_read(8'h11, 8'd3, 1);
    fork
      do_write(8'hA5, 3, 0, 0);
      do_read(8'h5B, 8'd5, 0);
    join
    chk("hit_concurrent", hit, 1);
    do_read(8'hE7, 8'd255, 2);
    repeat (24) begin
      k = $urandom % 3;
      if (k == 0) do_write(8'($urandom), 1 + $urandom % 6, $urandom % 3, $urandom % 4 == 0);
      else if (k == 1) do_read(8'($urandom), 8'($urandom % 12), $urandom % 3);
      else fork
        do_write(8'($urandom), 1 + $urandom % 6, $urandom % 3, 0);
        do_read(8'($urandom), 8'($urandom % 12), $urandom % 3);
      join
    end
    for (int i = 0; i < 8; i++) exp_r.push_back(rbeat_t'{id: 8'h5A, last: (i == 7)});
    arvalid = 1;
    arid = 8'h5A;
    arlen = 8'd7;
    step_until(3, 0, "ar_mid");
    arvalid = 0;
    step_until(4, 2, "r_mid");
    step_until(4, 2, "r_mid");
    rstn = 0;
    @(posedge clk);
    #1;
    exp_r.delete();
    rready = 0;
    nw = 0;
    nr = 0;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_arready", arready, 0);
    chk("midrst_wr_cnt", wr_cnt, 0);
    chk("midrst_rd_cnt", rd_cnt, 0);
    chk("midrst_sat_cnt", s_wr_cnt, 0);
    chk("midrst_hit", hit, 0);
    rstn = 1;
    #1;
    chk("midrel_arready", arready, 1);
    chk("midrel_awready", awready, 1);
    @(posedge clk);
    #1;
    chk("midrel_rvalid", rvalid, 0);
    do_read(8'h22, 8'd2, 0);
    do_write(8'h33, 2, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
